// File: rtl/keypad_sum_pkg.sv
// keypad_sum_pkg
// Shared definitions for the keypad sum entry block.
//   - Operand and output widths.
//   - Key codes for '+', '=' and clear.
//   - Entry state encoding. The encoding is driven straight onto entry_stage.
//   - A digit-key classifier.
package keypad_sum_pkg;

  localparam int MAX_DIGITS = 3;
  localparam int OP_W       = 10;
  localparam int OUT_W      = 14;
  localparam int CNT_W      = $clog2(MAX_DIGITS + 1);

  localparam logic [3:0] KEY_ADD = 4'hA;
  localparam logic [3:0] KEY_EQ  = 4'hB;
  localparam logic [3:0] KEY_CLR = 4'hC;

  typedef enum logic [1:0] {
    S_OP_A   = 2'b00,
    S_OP_B   = 2'b01,
    S_RESULT = 2'b10
  } entry_state_t;

  function automatic logic is_digit(input logic [3:0] k);
    return (k <= 4'd9);
  endfunction

endpackage

// File: rtl/decimal_accumulator.sv
// decimal_accumulator
// Combinational digit shifter. One instance serves whichever operand is
// currently being typed.
//   cur_val / cur_cnt : operand value and the number of digits typed so far.
//   digit             : new decimal digit (0-9).
//   nxt_val / nxt_cnt : value and count after the digit is appended.
//                       Both stay unchanged once MAX_DIGITS digits are present.
module decimal_accumulator
  import keypad_sum_pkg::*;
(
  input  logic [OP_W-1:0]  cur_val,
  input  logic [3:0]       digit,
  input  logic [CNT_W-1:0] cur_cnt,
  output logic [OP_W-1:0]  nxt_val,
  output logic [CNT_W-1:0] nxt_cnt
);

  localparam int EXT_W = OP_W + 4;

  // x*10 is built as (x<<3)+(x<<1) with 4 bits of headroom. The digit limit
  // keeps the result at or below 999, so truncating back to OP_W loses nothing.
  function automatic logic [EXT_W-1:0] times10_plus(input logic [OP_W-1:0] x,
                                                     input logic [3:0]      d);
    logic [EXT_W-1:0] xe;
    xe = EXT_W'(x);
    return (xe << 3) + (xe << 1) + EXT_W'(d);
  endfunction

  // Saturation on digit count: extra digits leave the operand untouched.
  function automatic logic digits_full(input logic [CNT_W-1:0] cnt);
    return (cnt >= CNT_W'(MAX_DIGITS));
  endfunction

  always_comb begin
    nxt_val = cur_val;
    nxt_cnt = cur_cnt;
    if (!digits_full(cur_cnt)) begin
      nxt_val = OP_W'(times10_plus(cur_val, digit));
      nxt_cnt = cur_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/keypad_sum_entry.sv
// keypad_sum_entry
// Builds two decimal operands from keypad events and adds them on '='.
// The value driven out is the operand being typed, or the finished sum.
// Ports:
//   clk          : system clock.
//   reset        : asynchronous active-low reset.
//   key_valid    : one-cycle strobe qualifying key_code.
//   key_code     : 0-9 digit, A '+', B '=', C clear, D-F ignored.
//   sum_result   : displayed value (op_a, op_b or sum), zero-extended.
//   entry_stage  : 00 entering A, 01 entering B, 10 result shown.
//   result_valid : one-cycle pulse in the cycle a new sum first appears.
// All outputs are registered and change one cycle after the key is accepted.
module keypad_sum_entry
  import keypad_sum_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             key_valid,
  input  logic [3:0]       key_code,
  output logic [OUT_W-1:0] sum_result,
  output logic [1:0]       entry_stage,
  output logic             result_valid
);

  entry_state_t     state_p1, state_p0;
  logic [OP_W-1:0]  op_a_p1, op_a_p0;
  logic [OP_W-1:0]  op_b_p1, op_b_p0;
  logic [OUT_W-1:0] sum_p1, sum_p0;
  logic [CNT_W-1:0] cnt_p1, cnt_p0;
  logic             rv_p0;
  logic [OUT_W-1:0] disp_p0;

  logic [OP_W-1:0]  acc_in;
  logic [OP_W-1:0]  acc_val;
  logic [CNT_W-1:0] acc_cnt;

  // The output mux works on next-state values, so sum_result is a register
  // that stays aligned with entry_stage.
  function automatic logic [OUT_W-1:0] disp_sel(input entry_state_t st,
                                                input logic [OP_W-1:0]  a,
                                                input logic [OP_W-1:0]  b,
                                                input logic [OUT_W-1:0] s);
    case (st)
      S_OP_B:   return OUT_W'(b);
      S_RESULT: return s;
      default:  return OUT_W'(a);
    endcase
  endfunction

  // The accumulator is shared by both operands. Only B is typed in S_OP_B.
  assign acc_in = (state_p1 == S_OP_B) ? op_b_p1 : op_a_p1;

  decimal_accumulator u_acc (
    .cur_val (acc_in),
    .digit   (key_code),
    .cur_cnt (cnt_p1),
    .nxt_val (acc_val),
    .nxt_cnt (acc_cnt)
  );

  // ---- Stage p0: key decode and next-state computation ----
  always_comb begin
    state_p0 = state_p1;
    op_a_p0  = op_a_p1;
    op_b_p0  = op_b_p1;
    sum_p0   = sum_p1;
    cnt_p0   = cnt_p1;
    rv_p0    = 1'b0;

    if (key_valid) begin
      if (key_code == KEY_CLR) begin
        state_p0 = S_OP_A;
        op_a_p0  = '0;
        op_b_p0  = '0;
        sum_p0   = '0;
        cnt_p0   = '0;
      end else begin
        case (state_p1)
          S_OP_A: begin
            if (is_digit(key_code)) begin
              op_a_p0 = acc_val;
              cnt_p0  = acc_cnt;
            end else if (key_code == KEY_ADD) begin
              state_p0 = S_OP_B;
              op_b_p0  = '0;
              cnt_p0   = '0;
            end
          end
          S_OP_B: begin
            if (is_digit(key_code)) begin
              op_b_p0 = acc_val;
              cnt_p0  = acc_cnt;
            end else if (key_code == KEY_EQ) begin
              // The adder is OP_W+1 bits wide so 999+999 cannot wrap.
              sum_p0   = OUT_W'({1'b0, op_a_p1} + {1'b0, op_b_p1});
              state_p0 = S_RESULT;
              rv_p0    = 1'b1;
            end
          end
          S_RESULT: begin
            // A digit starts a new entry and becomes the first digit of A.
            if (is_digit(key_code)) begin
              op_a_p0  = OP_W'(key_code);
              op_b_p0  = '0;
              cnt_p0   = CNT_W'(1);
              state_p0 = S_OP_A;
            end
          end
          default: state_p0 = S_OP_A;
        endcase
      end
    end

    disp_p0 = disp_sel(state_p0, op_a_p0, op_b_p0, sum_p0);
  end

  // ---- Stage p1: state and output registers ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_p1     <= S_OP_A;
      op_a_p1      <= '0;
      op_b_p1      <= '0;
      sum_p1       <= '0;
      cnt_p1       <= '0;
      sum_result   <= '0;
      entry_stage  <= 2'b00;
      result_valid <= 1'b0;
    end else begin
      state_p1     <= state_p0;
      op_a_p1      <= op_a_p0;
      op_b_p1      <= op_b_p0;
      sum_p1       <= sum_p0;
      cnt_p1       <= cnt_p0;
      sum_result   <= disp_p0;
      entry_stage  <= state_p0;
      result_valid <= rv_p0;
    end
  end

endmodule

// File: tb/tb_keypad_sum_entry.sv
module tb_keypad_sum_entry;
  import keypad_sum_pkg::*;

  logic             clk;
  logic             reset;
  logic             key_valid;
  logic [3:0]       key_code;
  logic [OUT_W-1:0] sum_result;
  logic [1:0]       entry_stage;
  logic             result_valid;

  int checks = 0;
  int errors = 0;

  // Calculator model. Operands are plain integers.
  int m_stage, m_a, m_b, m_s, m_nd, m_rv;

  keypad_sum_entry dut (
    .clk          (clk),
    .reset        (reset),
    .key_valid    (key_valid),
    .key_code     (key_code),
    .sum_result   (sum_result),
    .entry_stage  (entry_stage),
    .result_valid (result_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_clear();
    m_stage = 0; m_a = 0; m_b = 0; m_s = 0; m_nd = 0; m_rv = 0;
  endtask

  task automatic model_key(input int k);
    m_rv = 0;
    if (k == 12) begin
      model_clear();
    end else if (k <= 9) begin
      if (m_stage == 2) begin
        m_a = k; m_b = 0; m_nd = 1; m_stage = 0;
      end else if (m_nd < MAX_DIGITS) begin
        if (m_stage == 0) m_a = m_a * 10 + k;
        else              m_b = m_b * 10 + k;
        m_nd++;
      end
    end else if (k == 10 && m_stage == 0) begin
      m_stage = 1; m_b = 0; m_nd = 0;
    end else if (k == 11 && m_stage == 1) begin
      m_s = m_a + m_b; m_stage = 2; m_rv = 1;
    end
  endtask

  function automatic int model_disp();
    if (m_stage == 0) return m_a;
    if (m_stage == 1) return m_b;
    return m_s;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".sum_result"},   32'(sum_result),   32'(model_disp()));
    chk({tag, ".entry_stage"},  32'(entry_stage),  32'(m_stage));
    chk({tag, ".result_valid"}, 32'(result_valid), 32'(m_rv));
  endtask

  task automatic press(input int k);
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = 4'(k);
    @(negedge clk);
    key_valid = 1'b0;
    key_code  = 4'h0;
    model_key(k);
    check_all($sformatf("key%0h", k));
  endtask

  task automatic idle();
    @(negedge clk);
    m_rv = 0;
    check_all("idle");
  endtask

  initial begin
    int r;
    int k;
    reset     = 1'b0;
    key_valid = 1'b0;
    key_code  = 4'h0;
    model_clear();
    repeat (2) @(negedge clk);
    chk("rst.sum_result", 32'(sum_result), 32'd0);
    chk("rst.entry_stage", 32'(entry_stage), 32'd0);
    chk("rst.result_valid", 32'(result_valid), 32'd0);
    reset = 1'b1;
    idle();

    // 123 + 456 = 579
    press(1); press(2); press(3); press(10);
    press(4); press(5); press(6); press(11);
    chk("t1.sum", 32'(sum_result), 32'd579);
    chk("t1.pulse", 32'(result_valid), 32'd1);
    idle();
    chk("t1.pulse_gone", 32'(result_valid), 32'd0);

    // Fourth digit is ignored.
    press(12);
    press(9); press(9); press(9);
    chk("t2.999", 32'(sum_result), 32'd999);
    press(9);
    chk("t2.sat", 32'(sum_result), 32'd999);

    // 999 + 999 = 1998. A repeated '=' does not pulse again.
    press(12);
    press(9); press(9); press(9); press(10);
    press(9); press(9); press(9); press(11);
    chk("t3.max", 32'(sum_result), 32'h7CE);
    press(11);
    chk("t3.no_repulse", 32'(result_valid), 32'd0);

    // 5 + (nothing) = 5. '+' is ignored in S_RESULT. A digit restarts A.
    press(5); press(10); press(11);
    chk("t4.sum", 32'(sum_result), 32'd5);
    press(10);
    chk("t4.stage", 32'(entry_stage), 32'd2);
    press(7);
    chk("t4.new_a", 32'(sum_result), 32'd7);
    chk("t4.stage_a", 32'(entry_stage), 32'd0);

    // Clear mid-entry. 0xE is ignored.
    press(4); press(2); press(10); press(3); press(12);
    chk("t5.clr", 32'(sum_result), 32'd0);
    press(14);
    chk("t5.ignE", 32'(entry_stage), 32'd0);

    // Asynchronous reset mid-entry.
    press(8); press(10); press(6);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("t6.async_sum", 32'(sum_result), 32'd0);
    chk("t6.async_stage", 32'(entry_stage), 32'd0);
    repeat (3) @(negedge clk);
    chk("t6.held_sum", 32'(sum_result), 32'd0);
    chk("t6.held_rv", 32'(result_valid), 32'd0);
    reset = 1'b1;
    model_clear();
    press(2);
    chk("t6.a2", 32'(sum_result), 32'd2);
    press(11);
    chk("t6.eq_ignored", 32'(entry_stage), 32'd0);

    // Random key streams against the model.
    for (int i = 0; i < 500; i++) begin
      r = $urandom_range(0, 9);
      if (r < 6) k = $urandom_range(0, 9);
      else       k = $urandom_range(10, 15);
      press(k);
      if ($urandom_range(0, 3) == 0) idle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
